// File: rtl/move_executor.sv
// Runs one quarter-turn move: decodes the move code, then generates dir setup, the step pulse train and the settle time.
// The move_done pulse rises 2*SETTLE+2*STEP_HALF*STEPS_PER_QUARTER edges after acceptance, or 1 edge after acceptance for a no-op or invalid code.
module move_executor #(
    parameter int STEP_HALF         = 5000,
    parameter int STEPS_PER_QUARTER = 50,
    parameter int SETTLE            = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_move,
    input  logic [3:0] next_move,
    output logic [5:0] step,
    output logic [5:0] dir,
    output logic       move_done,
    output logic       busy,
    output logic       bad_code,
    output logic       overrun,
    output logic [7:0] moves_executed
);

    localparam int SET_W  = $clog2(SETTLE) + 1;
    localparam int HALF_W = $clog2(STEP_HALF) + 1;
    localparam int CW     = (SET_W > HALF_W) ? SET_W : HALF_W;
    localparam int SW     = $clog2(STEPS_PER_QUARTER) + 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] HALF_LAST   = CW'(STEP_HALF - 1);
    localparam logic [SW-1:0] QUARTER     = SW'(STEPS_PER_QUARTER);

    typedef enum logic [2:0] {IDLE, SETUP, STEP_HI, STEP_LO, POST, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [SW-1:0] steps, steps_next, steps_inc;
    logic [2:0]    motor, motor_next, motor_dec;
    logic          pend, pend_next;
    logic [5:0]    step_next, dir_next, motor_bit;
    logic          move_done_next, busy_next, bad_code_next, overrun_next;
    logic [7:0]    moves_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            steps          <= '0;
            motor          <= '0;
            pend           <= 1'b0;
            step           <= '0;
            dir            <= '0;
            move_done      <= 1'b0;
            busy           <= 1'b0;
            bad_code       <= 1'b0;
            overrun        <= 1'b0;
            moves_executed <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            steps          <= steps_next;
            motor          <= motor_next;
            pend           <= pend_next;
            step           <= step_next;
            dir            <= dir_next;
            move_done      <= move_done_next;
            busy           <= busy_next;
            bad_code       <= bad_code_next;
            overrun        <= overrun_next;
            moves_executed <= moves_next;
        end
    end

    // Codes 1-6 and 7-12 address the same six faces in opposite directions.
    assign motor_dec = 3'((next_move <= 4'd6) ? (next_move - 4'd1) : (next_move - 4'd7));
    assign motor_bit = 6'b000001 << motor;
    assign steps_inc = steps + SW'(1);

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        steps_next     = steps;
        motor_next     = motor;
        pend_next      = pend;
        step_next      = step;
        dir_next       = dir;
        move_done_next = 1'b0;
        busy_next      = busy;
        bad_code_next  = bad_code;
        overrun_next   = overrun;
        moves_next     = moves_executed;

        if (start_move && state != IDLE) begin
            overrun_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start_move) begin
                    busy_next = 1'b1;
                    if (next_move == 4'd0) begin
                        pend_next  = 1'b1;
                        state_next = DONE;
                    end else if (next_move <= 4'd12) begin
                        motor_next          = motor_dec;
                        dir_next[motor_dec] = (next_move <= 4'd6);
                        cnt_next            = '0;
                        steps_next          = '0;
                        state_next          = SETUP;
                    end else begin
                        bad_code_next = 1'b1;
                        pend_next     = 1'b1;
                        state_next    = DONE;
                    end
                end
            end
            SETUP: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_next   = '0;
                    step_next  = motor_bit;
                    state_next = STEP_HI;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STEP_HI: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    step_next  = '0;
                    state_next = STEP_LO;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STEP_LO: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    steps_next = steps_inc;
                    if (steps_inc < QUARTER) begin
                        step_next  = motor_bit;
                        state_next = STEP_HI;
                    end else begin
                        state_next = POST;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            POST: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_next       = '0;
                    move_done_next = 1'b1;
                    moves_next     = moves_executed + 8'd1;
                    pend_next      = 1'b0;
                    state_next     = DONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DONE: begin
                // A move that skipped the motor still owes its done pulse on the first DONE edge.
                if (pend) begin
                    move_done_next = 1'b1;
                    pend_next      = 1'b0;
                end else begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_move_executor.sv
// Bench for move_executor: table of moves plus hand sequences for overrun, reset mid-move and a sequencer model.
module tb_move_executor;

    localparam int SH  = 2;
    localparam int SPQ = 3;
    localparam int ST  = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_move;
    logic [3:0] next_move;
    logic [5:0] step;
    logic [5:0] dir;
    logic       move_done;
    logic       busy;
    logic       bad_code;
    logic       overrun;
    logic [7:0] moves_executed;

    move_executor #(.STEP_HALF(SH), .STEPS_PER_QUARTER(SPQ), .SETTLE(ST)) dut (
        .clock(clock), .reset(reset), .start_move(start_move), .next_move(next_move),
        .step(step), .dir(dir), .move_done(move_done), .busy(busy),
        .bad_code(bad_code), .overrun(overrun), .moves_executed(moves_executed)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         motor;
        int         lat;
        logic [5:0] dirv;
        logic       bad;
        logic [7:0] moves;
    } exp_t;

    typedef struct {
        logic [3:0] code;
        int         motor;
        logic       dirb;
        int         lat;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[8];
    vec_t       seq[4];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         start_edge = 0;
    int         dones = 0;
    int         pulse_cnt[6];
    int         total[6];
    int         hi_len[6];
    int         rise_rel[4];
    int         rise_n;
    logic [5:0] prev_step;
    logic       prev_done;
    logic [5:0] model_dir;
    logic       model_bad;
    logic [7:0] model_moves;
    logic       seq_done;
    int         tot0[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: counts step pulses and scores every move_done against the queue.
    always @(negedge clock) begin
        if (reset) begin
            for (int m = 0; m < 6; m++) begin
                pulse_cnt[m] = 0;
                hi_len[m]    = 0;
            end
            rise_n    = 0;
            prev_step = '0;
            prev_done = 1'b0;
        end else begin
            if ($countones(step) > 1) chk("step_onehot", 32'(step), 32'(step & -step));
            for (int m = 0; m < 6; m++) begin
                if (step[m] && !prev_step[m]) begin
                    pulse_cnt[m]++;
                    total[m]++;
                    if (rise_n < 4) rise_rel[rise_n] = cyc - start_edge;
                    rise_n++;
                end
                if (step[m]) hi_len[m]++;
                if (!step[m] && prev_step[m]) begin
                    chk("step_high_len", 32'(hi_len[m]), 32'(SH));
                    hi_len[m] = 0;
                end
            end
            if (move_done) begin
                if (prev_done) begin
                    chk("done_one_cycle", 32'(prev_done), 32'(0));
                end else if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(dones + 1), 32'(dones));
                    dones++;
                end else begin
                    exp_t e;
                    int   sum;
                    e = sb.pop_front();
                    dones++;
                    sum = 0;
                    for (int m = 0; m < 6; m++) sum += pulse_cnt[m];
                    chk("done_latency", 32'(cyc - start_edge), 32'(e.lat));
                    chk("pulse_total", 32'(sum), 32'((e.motor >= 0) ? SPQ : 0));
                    if (e.motor >= 0) begin
                        chk("pulse_motor", 32'(pulse_cnt[e.motor]), 32'(SPQ));
                        chk("rise_edges", {8'(rise_rel[0]), 8'(rise_rel[1]), 8'(rise_rel[2])},
                            {8'(ST), 8'(ST + 2 * SH), 8'(ST + 4 * SH)});
                    end
                    chk("dir", 32'(dir), 32'(e.dirv));
                    chk("bad_code", 32'(bad_code), 32'(e.bad));
                    chk("moves_executed", 32'(moves_executed), 32'(e.moves));
                    chk("step_idle_at_done", 32'(step), 32'(0));
                    for (int m = 0; m < 6; m++) pulse_cnt[m] = 0;
                    rise_n = 0;
                end
            end
            prev_step = step;
            prev_done = move_done;
        end
    end

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (dones == prev && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk("done_seen", 32'(dones != prev), 32'(1));
    endtask

    task automatic run_move(input logic [3:0] code, input int motor, input logic dirb,
                            input int lat, input int ovr_at);
        exp_t e;
        int   prev;
        if (motor >= 0) begin
            model_dir[motor] = dirb;
            model_moves++;
        end else if (code >= 4'd13) begin
            model_bad = 1'b1;
        end
        e.motor = motor; e.lat = lat; e.dirv = model_dir; e.bad = model_bad; e.moves = model_moves;
        sb.push_back(e);
        prev       = dones;
        start_edge = cyc + 1;
        start_move = 1'b1;
        next_move  = code;
        @(posedge clock); #1;
        start_move = 1'b0;
        next_move  = 4'($urandom_range(0, 15));
        chk("busy_on", 32'(busy), 32'(1));
        if (ovr_at > 0) begin
            repeat (ovr_at - 1) begin @(posedge clock); #1; end
            start_move = 1'b1;
            next_move  = 4'd5;
            @(posedge clock); #1;
            start_move = 1'b0;
            chk("overrun_set", 32'(overrun), 32'(1));
        end
        wait_done(prev);
        chk("busy_off", 32'(busy), 32'(0));
        chk("done_cleared", 32'(move_done), 32'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        model_dir   = '0;
        model_bad   = 1'b0;
        model_moves = '0;
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'd1,  0,  1'b1, 20};
        vecs[1] = '{4'd12, 5,  1'b0, 20};
        vecs[2] = '{4'd0,  -1, 1'b0, 1};
        vecs[3] = '{4'd14, -1, 1'b0, 1};
        vecs[4] = '{4'd6,  5,  1'b1, 20};
        vecs[5] = '{4'd7,  0,  1'b0, 20};
        vecs[6] = '{4'd15, -1, 1'b0, 1};
        vecs[7] = '{4'd10, 3,  1'b0, 20};
        seq[0]  = '{4'd1, 0, 1'b1, 20};
        seq[1]  = '{4'd7, 0, 1'b0, 20};
        seq[2]  = '{4'd3, 2, 1'b1, 20};
        seq[3]  = '{4'd9, 2, 1'b0, 20};
        for (int m = 0; m < 6; m++) total[m] = 0;
        start_move = 1'b0;
        next_move  = 4'd0;
        seq_done   = 1'b0;
        @(posedge clock); #1;
        do_reset();

        chk("rst_step", 32'(step), 32'(0));
        chk("rst_dir", 32'(dir), 32'(0));
        chk("rst_done_busy", {30'd0, move_done, busy}, 32'(0));
        chk("rst_flags", {30'd0, bad_code, overrun}, 32'(0));
        chk("rst_moves", 32'(moves_executed), 32'(0));

        for (int i = 0; i < 8; i++) begin
            run_move(vecs[i].code, vecs[i].motor, vecs[i].dirb, vecs[i].lat, 0);
            repeat (2) begin @(posedge clock); #1; end
        end
        chk("overrun_clear_before", 32'(overrun), 32'(0));

        run_move(4'd3, 2, 1'b1, 20, 6);
        repeat (30) begin @(posedge clock); #1; end
        chk("overrun_sticky", 32'(overrun), 32'(1));
        chk("bad_sticky", 32'(bad_code), 32'(1));

        // Reset sampled ten edges into a code-1 move.
        begin
            exp_t e;
            int   prev;
            e.motor = 0; e.lat = 20; e.dirv = 6'b000001; e.bad = 1'b0; e.moves = 8'd0;
            sb.push_back(e);
            prev       = dones;
            start_edge = cyc + 1;
            start_move = 1'b1;
            next_move  = 4'd1;
            @(posedge clock); #1;
            start_move = 1'b0;
            repeat (9) begin @(posedge clock); #1; end
            chk("step_before_rst", 32'(step), 32'(6'b000001));
            reset = 1'b1;
            sb.delete();
            @(posedge clock); #1;
            chk("rst_mid_step", 32'(step), 32'(0));
            chk("rst_mid_outputs", {dir, move_done, busy, bad_code, overrun, moves_executed}, 32'(0));
            reset       = 1'b0;
            model_dir   = '0;
            model_bad   = 1'b0;
            model_moves = '0;
            repeat (30) begin @(posedge clock); #1; end
            chk("no_done_after_rst", 32'(dones), 32'(prev));
        end
        run_move(4'd2, 1, 1'b1, 20, 0);

        // Sequencer model: four moves, two-cycle gap after each done.
        do_reset();
        for (int m = 0; m < 6; m++) tot0[m] = total[m];
        seq_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_move(seq[i].code, seq[i].motor, seq[i].dirb, seq[i].lat, 0);
            repeat (2) begin @(posedge clock); #1; end
        end
        seq_done = 1'b1;
        chk("seq_done", 32'(seq_done), 32'(1));
        chk("seq_pulses_m0", 32'(total[0] - tot0[0]), 32'(2 * SPQ));
        chk("seq_pulses_m2", 32'(total[2] - tot0[2]), 32'(2 * SPQ));
        chk("seq_pulses_other", 32'((total[1] - tot0[1]) + (total[3] - tot0[3]) +
                                    (total[4] - tot0[4]) + (total[5] - tot0[5])), 32'(0));
        chk("seq_moves", 32'(moves_executed), 32'(4));
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/move_executor.md
Name: move_executor

Overview:
- Consumes one 4-bit move code per start_move pulse from the upstream move sequencer.
- Turns the move into step/dir pulse trains for one of six face stepper drivers (U, D, L, R, F, B).
- Returns a single-cycle move_done pulse when the quarter turn and the settle time are complete.
- Sits between the sequencer and the stepper driver pins. One move is in flight at a time.

Parameters:
- STEP_HALF, default 5000: clock cycles per half step period (step high time = step low time); minimum 1.
- STEPS_PER_QUARTER, default 50: full steps per 90-degree face turn; minimum 1.
- SETTLE, default 20000: clock cycles of dir setup before the first step, and again after the last step; minimum 1.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- start_move  input  1  single-cycle request; samples next_move
- next_move  input  4  move code
- step  output  6  step pulse per motor; bit0=U, 1=D, 2=L, 3=R, 4=F, 5=B
- dir  output  6  direction per motor; 1 = clockwise
- move_done  output  1  single-cycle completion pulse
- busy  output  1  high from acceptance until move_done
- bad_code  output  1  sticky; an invalid code was received
- overrun  output  1  sticky; start_move arrived while busy
- moves_executed  output  8  count of completed valid moves, wraps 255->0

Behaviour:
- Reset values: step=0, dir=0, move_done=0, busy=0, bad_code=0, overrun=0, moves_executed=0, state=IDLE.
- Reset mid-move: step drops to 0 at the next edge and the move is abandoned. No move_done is generated.
- Code map:
  - 0: no-op.
  - 1-6: faces U, D, L, R, F, B clockwise.
  - 7-12: the same faces counter-clockwise.
  - 13-15: invalid.
  - Motor index for codes 1-12 = (code-1) mod 6.
- States: IDLE, SETUP, STEP_HI, STEP_LO, POST, DONE.
- IDLE:
  - busy=0. On start_move at edge k with a valid code 1-12:
    - dir[m] set to 1 for codes 1-6, 0 for 7-12.
    - Other dir bits are unchanged.
    - busy<=1, cycle counter cleared, state<=SETUP.
  - Code 0: state<=DONE, busy<=1.
  - Codes 13-15: bad_code<=1, state<=DONE, busy<=1.
- SETUP: hold for SETTLE cycles. At edge k+SETTLE, step[m]<=1 and state<=STEP_HI.
- STEP_HI: hold STEP_HALF cycles, then step[m]<=0 and state<=STEP_LO.
- STEP_LO:
  - Hold STEP_HALF cycles, then increment the step counter.
  - If count < STEPS_PER_QUARTER: step[m]<=1, state<=STEP_HI.
  - Else: state<=POST.
  - The last low phase ends at edge k+SETTLE+2*STEP_HALF*STEPS_PER_QUARTER.
- POST: hold SETTLE cycles. At its end, move_done<=1, state<=DONE.
  - Valid move: move_done rises at edge k+2*SETTLE+2*STEP_HALF*STEPS_PER_QUARTER.
- DONE:
  - If entered from POST: moves_executed<=moves_executed+1.
  - If entered directly from IDLE (code 0 or invalid): move_done<=1 at this edge. move_done therefore rises at edge k+1.
  - Next edge: move_done<=0, busy<=0, state<=IDLE.
- move_done is high for exactly one cycle per accepted start_move. Earliest rise is edge k+1, which the sequencer's two-cycle wait tolerates.
- Only one step bit is ever high. step is never asserted outside STEP_HI.
- start_move while busy (any state other than IDLE, including DONE): the request is ignored and overrun<=1.
- start_move in IDLE on the same edge that DONE returns to IDLE cannot occur; DONE and IDLE are exclusive.
- Counter widths: $clog2 of the respective parameter + 1. No overflow for legal parameters.
- Sticky flags clear only on reset.

Test Plan:
- Use STEP_HALF=2, STEPS_PER_QUARTER=3, SETTLE=4 throughout.
- Reset, start_move with code 1 at edge 0 -> dir[0]=1 at edge 0; step[0] rises at edges 4, 8, 12 (high 2 cycles each); move_done high for one cycle from edge 20; moves_executed=1; busy low from edge 21.
- Code 12 -> motor 5 (B) used, dir[5]=0, dir[0] retains 1 from the prior move; 3 step pulses on step[5] only; move_done at edge 20.
- Code 0, then code 14 -> each gives move_done at edge k+1 and no step activity; bad_code=1 after code 14; moves_executed unchanged.
- start_move pulsed again at edge 6 during a code-3 move -> overrun=1; the move completes normally with exactly 3 pulses and one move_done.
- Reset asserted at edge 9 mid-move -> step=0 at edge 10; no move_done; all outputs at reset values; a following code-2 move runs normally.
- Drive with the sequencer model loading 4 moves [1, 7, 3, 9] -> 12 total step pulses on motors 0, 0, 2, 2; dir sequence 1, 0, 1, 0; moves_executed=4; sequencer seq_done asserts.
